// File: rtl/uart_receiver.sv
// UART 8N1 receive stage: 2-FF synchronised rx, mid-bit sampling, sticky rdy/overrun and framing status.
// Optional even-parity bit and parity_err port when UART_RX_PARITY_EN is defined.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       rx_busy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       overrun,
  output logic       parity_err
`else
  output logic       overrun
`endif
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic             rx_s1, rx_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       dout_nxt;
  logic             rdy_nxt, rx_busy_nxt, frame_err_nxt, overrun_nxt;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_bit_nxt;
  logic             parity_err_nxt;
`endif

  // Synchroniser and all state/output registers
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      dout       <= 8'h00;
      rdy        <= 1'b0;
      rx_busy    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_s1      <= rx;
      rx_s       <= rx_s1;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shift      <= shift_nxt;
      dout       <= dout_nxt;
      rdy        <= rdy_nxt;
      rx_busy    <= rx_busy_nxt;
      frame_err  <= frame_err_nxt;
      overrun    <= overrun_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_nxt;
      parity_err <= parity_err_nxt;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_W'(1);
    idx_nxt        = idx;
    shift_nxt      = shift;
    dout_nxt       = dout;
    rdy_nxt        = rdy;
    frame_err_nxt  = frame_err;
    overrun_nxt    = overrun;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt    = par_bit;
    parity_err_nxt = parity_err;
`endif

    if (rdy_clr) begin
      rdy_nxt     = 1'b0;
      overrun_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[7:1]};
          idx_nxt   = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx == 3'd7) state_nxt = PARITY;
`else
          if (idx == 3'd7) state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          par_bit_nxt = rx_s;
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            dout_nxt      = shift;
            rdy_nxt       = 1'b1;
            frame_err_nxt = 1'b0;
            // Newest byte wins; overrun only if the consumer had not taken the previous one
            if (rdy && !rdy_clr) overrun_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_nxt = ^{shift, par_bit};
`endif
            state_nxt = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    rx_busy_nxt = (state_nxt != IDLE);
  end

endmodule
